// File: rtl/receiver_block_streamer.sv
// receiver_block_streamer
//
// Streams the decoded blocks held in the receiver RAM out as a byte frame:
//   0xA5, N, then for each block k = 0..N-1 six bytes ({7'b0, block_wanted}, MSB first),
//   then an XOR checksum of every byte from N through the last block byte.
// A block whose fetch does not complete within TIMEOUT_CYCLES is sent as six 0xFF bytes,
// and timeout_count is bumped (saturating).
//
// Ports
//   clk_96MHz           in   1   sole clock, rising edge
//   reset               in   1   asynchronous, active-high
//   enabled             in   1   gates the start of a new frame only
//   avl_blocks_nb       in   8   number of decoded blocks available in RAM
//   block_wanted        in  41   selected block: [40:24] data, [23:0] timestamp
//   data_ready          in   1   one-cycle pulse, block_wanted valid for block_wanted_number
//   block_wanted_number out  8   RAM block index being requested
//   tx_data             out  8   outgoing byte
//   tx_valid            out  1   tx_data valid
//   tx_ready            in   1   downstream accepts
//   busy                out  1   frame in progress
//   timeout_count       out  8   saturating count of failed block fetches
module receiver_block_streamer #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [7:0]  MAX_BLOCKS     = 8'd255
) (
    input  logic        clk_96MHz,
    input  logic        reset,
    input  logic        enabled,
    input  logic [7:0]  avl_blocks_nb,
    input  logic [40:0] block_wanted,
    input  logic        data_ready,
    output logic [7:0]  block_wanted_number,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  timeout_count
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StCount,
        StReq,
        StWait,
        StSend,
        StChk
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        n_q, n_d;          // blocks in this frame, latched at start
    logic [7:0]        k_q, k_d;          // current block index
    logic [7:0]        chk_q, chk_d;
    logic [47:0]       shift_q, shift_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [7:0]        bwn_q, bwn_d;
    logic [7:0]        tmo_q, tmo_d;

    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            n_q        <= 8'd0;
            k_q        <= 8'd0;
            chk_q      <= 8'd0;
            shift_q    <= 48'd0;
            byte_cnt_q <= 3'd0;
            timer_q    <= '0;
            bwn_q      <= 8'd0;
            tmo_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            chk_q      <= chk_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            timer_q    <= timer_d;
            bwn_q      <= bwn_d;
            tmo_q      <= tmo_d;
        end
    end

    // Outputs depend only on registered state, so tx_data cannot move during a stall.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        k_d        = k_q;
        chk_d      = chk_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        timer_d    = timer_q;
        bwn_d      = bwn_q;
        tmo_d      = tmo_q;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;

        case (state_q)
            StIdle: begin
                if (enabled && (avl_blocks_nb != 8'd0)) begin
                    n_d     = (avl_blocks_nb > MAX_BLOCKS) ? MAX_BLOCKS : avl_blocks_nb;
                    k_d     = 8'd0;
                    chk_d   = 8'd0;
                    state_d = StSync;
                end
            end
            StSync: begin
                tx_valid = 1'b1;
                tx_data  = 8'hA5;
                if (tx_ready) begin
                    state_d = StCount;
                end
            end
            StCount: begin
                tx_valid = 1'b1;
                tx_data  = n_q;
                if (tx_ready) begin
                    chk_d   = chk_q ^ n_q;
                    bwn_d   = k_q;
                    state_d = StReq;
                end
            end
            StReq: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (data_ready) begin
                    shift_d    = {7'b0, block_wanted};
                    byte_cnt_d = 3'd0;
                    state_d    = StSend;
                end else if (timer_q == TimerLast) begin
                    shift_d    = '1;
                    byte_cnt_d = 3'd0;
                    if (tmo_q != 8'hFF) begin
                        tmo_d = tmo_q + 8'd1;
                    end
                    state_d    = StSend;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StSend: begin
                tx_valid = 1'b1;
                tx_data  = shift_q[47:40];
                if (tx_ready) begin
                    chk_d      = chk_q ^ shift_q[47:40];
                    shift_d    = {shift_q[39:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd5) begin
                        if (k_q < (n_q - 8'd1)) begin
                            k_d     = k_q + 8'd1;
                            bwn_d   = k_q + 8'd1;
                            state_d = StReq;
                        end else begin
                            state_d = StChk;
                        end
                    end
                end
            end
            StChk: begin
                tx_valid = 1'b1;
                tx_data  = chk_q;
                if (tx_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign block_wanted_number = bwn_q;
    assign busy                = (state_q != StIdle);
    assign timeout_count       = tmo_q;

endmodule

// File: tb/tb_receiver_block_streamer.sv
// Directed bench for receiver_block_streamer: checks reset values, a single-block frame,
// a throttled three-block frame, a fetch timeout, reset mid-frame and frame gating by
// enabled / latching of avl_blocks_nb.
module tb_receiver_block_streamer;

    logic        clk_96MHz = 1'b0;
    logic        reset = 1'b1;
    logic        enabled = 1'b0;
    logic [7:0]  avl_blocks_nb = 8'd0;
    logic [40:0] block_wanted = 41'd0;
    logic        data_ready = 1'b0;
    logic [7:0]  block_wanted_number;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic [7:0]  timeout_count;

    receiver_block_streamer #(
        .TIMEOUT_CYCLES(64),
        .MAX_BLOCKS(8'd255)
    ) dut (
        .clk_96MHz(clk_96MHz),
        .reset(reset),
        .enabled(enabled),
        .avl_blocks_nb(avl_blocks_nb),
        .block_wanted(block_wanted),
        .data_ready(data_ready),
        .block_wanted_number(block_wanted_number),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .timeout_count(timeout_count)
    );

    always #5 clk_96MHz = ~clk_96MHz;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          runs_q[$];
    int          run_len = 0;
    logic [40:0] blk[8];
    logic        skip[8];
    logic        toggle_ready = 1'b0;
    int          req_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // RAM model: answers a request 3 cycles after the REQ cycle unless that block is skipped.
    always @(posedge clk_96MHz) begin
        #1;
        if (toggle_ready) tx_ready = ~tx_ready;
        else              tx_ready = 1'b1;
        if (busy && !tx_valid) req_cnt++;
        else                   req_cnt = 0;
        if (req_cnt == 4 && !skip[block_wanted_number[2:0]]) begin
            data_ready   = 1'b1;
            block_wanted = blk[block_wanted_number[2:0]];
        end else begin
            data_ready   = 1'b0;
            block_wanted = 41'd0;
        end
    end

    // Byte collector, stall checker and request-gap measurement.
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'd0;
    always @(negedge clk_96MHz) begin
        if (!reset) begin
            if (pv && !pr) begin
                check_eq("stall_valid", tx_valid, 1);
                check_eq("stall_data", tx_data, pd);
            end
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (busy && !tx_valid) begin
                run_len++;
            end else if (run_len != 0) begin
                runs_q.push_back(run_len);
                run_len = 0;
            end
        end else begin
            run_len = 0;
        end
        pv = tx_valid && !reset;
        pr = tx_ready;
        pd = tx_data;
    end

    task automatic step();
        @(negedge clk_96MHz);
        #1;
    endtask

    task automatic load_exp(input logic [319:0] v, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(v[8*(n-1-i) +: 8]);
    endtask

    // Reference frame built from the block table (used for the longer 5-block frame).
    task automatic build_exp(input int n);
        logic [47:0] word;
        logic [7:0]  b;
        logic [7:0]  chk;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(n[7:0]);
        chk = n[7:0];
        for (int k = 0; k < n; k++) begin
            word = skip[k] ? 48'hFFFF_FFFF_FFFF : {7'b0, blk[k]};
            for (int j = 0; j < 6; j++) begin
                b = word[47 - 8*j -: 8];
                exp_q.push_back(b);
                chk = chk ^ b;
            end
        end
        exp_q.push_back(chk);
    endtask

    task automatic compare_frame(input string name);
        check_eq({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s_b%0d", name, i), got_q[i], exp_q[i]);
    endtask

    task automatic run_frame(input int budget);
        int c = 0;
        bit seen = 1'b0;
        got_q.delete();
        runs_q.delete();
        enabled = 1'b1;
        while (c < budget) begin
            step();
            c++;
            if (busy) seen = 1'b1;
            else if (seen) break;
        end
        enabled = 1'b0;
        check_eq("frame_done", seen && !busy, 1);
    endtask

    initial begin
        int c;
        for (int i = 0; i < 8; i++) begin
            blk[i]  = 41'd0;
            skip[i] = 1'b0;
        end

        // Reset values
        repeat (3) step();
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_bwn", block_wanted_number, 0);
        check_eq("rst_tmo", timeout_count, 0);
        reset = 1'b0;
        step();

        // Single block, full-rate sink
        blk[0] = 41'h12_3456_789A;
        avl_blocks_nb = 8'd1;
        run_frame(300);
        load_exp(320'hA5_01_00_12_34_56_78_9A_93, 9);
        compare_frame("t1");
        check_eq("t1_nruns", runs_q.size(), 1);
        if (runs_q.size() > 0) check_eq("t1_req_gap", runs_q[0], 4);
        check_eq("t1_tmo", timeout_count, 0);

        // Three blocks, tx_ready toggling every cycle
        blk[0] = 41'h000_0000_0001;
        blk[1] = 41'h1FF_FFFF_FFFF;
        blk[2] = 41'h0F0_F0F0_F0F0;
        avl_blocks_nb = 8'd3;
        toggle_ready = 1'b1;
        run_frame(600);
        toggle_ready = 1'b0;
        load_exp(320'hA5_03_00_00_00_00_00_01_01_FF_FF_FF_FF_FF_00_F0_F0_F0_F0_F0_0C, 21);
        compare_frame("t2");
        check_eq("t2_bwn_hold", block_wanted_number, 2);

        // Block 1 never answered -> timeout, six FF bytes
        blk[0] = 41'h1AB_CDEF_0123;
        skip[1] = 1'b1;
        avl_blocks_nb = 8'd2;
        run_frame(600);
        skip[1] = 1'b0;
        load_exp(320'hA5_02_01_AB_CD_EF_01_23_FF_FF_FF_FF_FF_FF_A8, 15);
        compare_frame("t3");
        check_eq("t3_nruns", runs_q.size(), 2);
        if (runs_q.size() > 1) check_eq("t3_timeout_gap", runs_q[1], 65);
        check_eq("t3_tmo", timeout_count, 1);
        check_eq("t3_bwn_hold", block_wanted_number, 1);

        // Reset while the third block byte is presented
        blk[0] = 41'h12_3456_789A;
        avl_blocks_nb = 8'd1;
        got_q.delete();
        enabled = 1'b1;
        c = 0;
        while (c < 200 && got_q.size() < 4) begin
            step();
            c++;
        end
        enabled = 1'b0;
        check_eq("t4_reached", got_q.size(), 4);
        @(posedge clk_96MHz);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t4_tx_valid", tx_valid, 0);
        check_eq("t4_tx_data", tx_data, 0);
        check_eq("t4_busy", busy, 0);
        check_eq("t4_bwn", block_wanted_number, 0);
        check_eq("t4_tmo", timeout_count, 0);
        repeat (3) step();
        reset = 1'b0;
        repeat (10) step();
        check_eq("t4_no_bytes", got_q.size(), 4);
        check_eq("t4_idle", busy, 0);
        run_frame(300);
        load_exp(320'hA5_01_00_12_34_56_78_9A_93, 9);
        compare_frame("t4r");

        // enabled gating and avl_blocks_nb latched at start
        blk[0] = 41'h000_0000_00AA;
        blk[1] = 41'h155_5555_5555;
        blk[2] = 41'h0CC_CCCC_CCCC;
        blk[3] = 41'h001_0000_0000;
        blk[4] = 41'h0DE_ADBE_EF00;
        blk[5] = 41'h111_1111_1111;
        blk[6] = 41'h022_2222_2222;
        avl_blocks_nb = 8'd5;
        got_q.delete();
        repeat (20) step();
        check_eq("t5_gated_bytes", got_q.size(), 0);
        check_eq("t5_gated_busy", busy, 0);
        enabled = 1'b1;
        c = 0;
        while (c < 100 && got_q.size() < 2) begin
            step();
            c++;
        end
        avl_blocks_nb = 8'd7;
        enabled = 1'b0;
        c = 0;
        while (c < 1000 && busy) begin
            step();
            c++;
        end
        check_eq("t5_done", busy, 0);
        build_exp(5);
        compare_frame("t5");
        repeat (10) step();
        check_eq("t5_no_restart", busy, 0);
        check_eq("t5_no_extra", got_q.size(), 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/receiver_block_streamer.md
RECEIVER_BLOCK_STREAMER -- requirements
Module: receiver_block_streamer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: cycles to wait for data_ready before declaring a block fetch failed.
REQ-002 SHALL have parameter MAX_BLOCKS, default 8'd255: upper cap on blocks per frame.
REQ-003 SHALL have: clk_96MHz  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have: enabled  in  1  receiver configured; new frames start only while high.
REQ-006 SHALL have: avl_blocks_nb  in  8  number of decoded blocks held in the receiver RAM.
REQ-007 SHALL have: block_wanted  in  41  selected block; [40:24] decoded data, [23:0] timestamp.
REQ-008 SHALL have: data_ready  in  1  one-cycle pulse: block_wanted is valid for the current block_wanted_number.
REQ-009 SHALL have: block_wanted_number  out  8  RAM block index being requested.
REQ-010 SHALL have: tx_data  out  8  outgoing byte.
REQ-011 SHALL have: tx_valid  out  1  tx_data valid.
REQ-012 SHALL have: tx_ready  in  1  downstream byte sink accepts.
REQ-013 SHALL have: busy  out  1  frame in progress.
REQ-014 SHALL have: timeout_count  out  8  saturating count of failed block fetches.

Function
REQ-015 SHALL implement states IDLE, SYNC, COUNT, REQ, WAIT, SEND, CHK.
REQ-016 IDLE -> SYNC when enabled=1 and avl_blocks_nb!=0; N latched = min(avl_blocks_nb, MAX_BLOCKS), block index k=0, checksum=0.
REQ-017 avl_blocks_nb changes after the latch SHALL NOT affect the current frame.
REQ-018 SYNC SHALL present 8'hA5 (not checksummed); COUNT SHALL present N.
REQ-019 A byte transfers on a cycle with tx_valid=1 and tx_ready=1; state advances on that edge.
REQ-020 While tx_valid=1 and tx_ready=0, tx_data SHALL hold stable and tx_valid SHALL remain 1.
REQ-021 Throughput SHALL be one byte per cycle when tx_ready is held high within SYNC/COUNT/SEND/CHK.
REQ-022 REQ SHALL drive block_wanted_number=k for one cycle, tx_valid=0, then enter WAIT with a timer cleared.
REQ-023 WAIT: on data_ready=1, latch {7'b0, block_wanted} into a 48-bit shift register, -> SEND.
REQ-024 WAIT: if TIMEOUT_CYCLES elapse without data_ready, latch 48'hFFFF_FFFF_FFFF, increment timeout_count (saturate at 255), -> SEND.
REQ-025 data_ready outside WAIT SHALL be ignored.
REQ-026 SEND SHALL emit the 48-bit word as 6 bytes, MSB first.
REQ-027 After the 6th byte: k<N-1 -> k=k+1, REQ; k=N-1 -> CHK.
REQ-028 Checksum SHALL be XOR of every transferred byte from COUNT through the last SEND byte; CHK presents it, -> IDLE after transfer.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 enabled falling mid-frame SHALL NOT abort the frame; only new frame starts are gated.
REQ-031 block_wanted_number SHALL hold its last value outside REQ/WAIT.
REQ-032 Back-to-back frames: IDLE SHALL be occupied at least one cycle between frames.

Reset
REQ-033 Asserting reset SHALL immediately force IDLE, tx_valid=0, tx_data=0, block_wanted_number=0, busy=0, timeout_count=0, checksum=0, k=0.
REQ-034 Reset mid-frame SHALL discard the partial frame; no byte is emitted until reset deasserts and REQ-016 is met.

Verification
REQ-035 avl=1, block_wanted=41'h1_2345_6789A (data 17'h12345>>... as supplied), data_ready 3 cycles after REQ, tx_ready=1 -> bytes A5,01,six block bytes MSB first, XOR checksum; busy low after.
REQ-036 avl=3, tx_ready toggling 1/0 every cycle -> 21 bytes total (A5,03,18 data,chk), tx_data stable during every stall.
REQ-037 avl=2, data_ready never pulses for block 1 -> block 1 sent as six FF bytes after 64 cycles, timeout_count=1, checksum covers FF bytes.
REQ-038 avl=1, reset asserted during 3rd SEND byte -> tx_valid=0 same cycle, all outputs at reset values, no further bytes until new start.
REQ-039 enabled=0, avl=5 -> no bytes, busy=0; enabled rising -> frame with N=5; avl changed to 7 mid-frame -> N byte still 05, 5 blocks sent.
